// File: rtl/firebird7_in_gate2_ijtag_drv_pkg.sv
// Shared types for the gate2 IJTAG TDR driver: CSU sequencer state encoding.
package firebird7_in_gate2_ijtag_drv_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    StIdle,
    StCapture,
    StShift,
    StUpdate,
    StDone
  } drv_state_e;

  // Segment is selected for the whole capture-shift-update window only.
  function automatic logic seg_active(drv_state_e st);
    return (st == StCapture) || (st == StShift) || (st == StUpdate);
  endfunction

endpackage

// File: rtl/firebird7_in_gate2_ijtag_tdr_driver_if.sv
// Request/response handshake between a bench/BIST requester and the TDR driver.
interface firebird7_in_gate2_ijtag_tdr_driver_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = $clog2(DATA_WIDTH + 1)
);
  logic                  req_valid;
  logic                  req_ready;
  logic [LEN_W-1:0]      req_len;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_noupd;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_len, req_data, req_noupd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_len, req_data, req_noupd, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/firebird7_in_gate2_ijtag_drv_shreg.sv
// Write-data shifter (serial si out, bit 0 first) and index-addressed so capture register.
module firebird7_in_gate2_ijtag_drv_shreg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  input  logic                  sample_en,
  input  logic [LEN_W-1:0]      sample_idx,
  input  logic                  so,
  output logic                  si,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  logic [DATA_WIDTH-1:0] sh_q;
  logic                  si_q;
  logic [DATA_WIDTH-1:0] rsp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
      si_q <= 1'b0;
    end else begin
      // si is only non-zero in cycles that the next state marks as SHIFT.
      si_q <= shift_en ? sh_q[0] : 1'b0;
      if (load) begin
        sh_q <= load_data;
      end else if (shift_en) begin
        sh_q <= sh_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else if (load) begin
      rsp_q <= '0;
    end else if (sample_en) begin
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
        if (sample_idx == LEN_W'(i)) rsp_q[i] <= so;
      end
    end
  end

  assign si       = si_q;
  assign rsp_data = rsp_q;

endmodule

// File: rtl/firebird7_in_gate2_ijtag_tdr_driver.sv
// IJTAG initiator: runs one capture-shift-update sequence per accepted request on one TDR segment.
module firebird7_in_gate2_ijtag_tdr_driver
  import firebird7_in_gate2_ijtag_drv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  firebird7_in_gate2_ijtag_tdr_driver_if.slave bus,
  output logic ijtag_sel,
  output logic ijtag_ce,
  output logic ijtag_se,
  output logic ijtag_ue,
  output logic ijtag_si,
  input  logic ijtag_so
);

  localparam logic [LEN_W-1:0] LenMax = LEN_W'(DATA_WIDTH);

  drv_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             noupd_q, noupd_d;
  logic             accept;
  logic [LEN_W-1:0] eff_len;
  logic             last_shift;
  logic             sel_q, ce_q, se_q, ue_q, rsp_valid_q;

  assign eff_len    = (bus.req_len > LenMax) ? LenMax : bus.req_len;
  assign last_shift = (cnt_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    noupd_d = noupd_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          len_d   = eff_len;
          noupd_d = bus.req_noupd;
          state_d = StCapture;
        end
      end
      StCapture: begin
        cnt_d = '0;
        if (len_q == '0) begin
          state_d = noupd_q ? StDone : StUpdate;
        end else begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (last_shift) begin
          state_d = noupd_q ? StDone : StUpdate;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      StUpdate: state_d = StDone;
      StDone: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      noupd_q     <= 1'b0;
      sel_q       <= 1'b0;
      ce_q        <= 1'b0;
      se_q        <= 1'b0;
      ue_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      noupd_q     <= noupd_d;
      sel_q       <= seg_active(state_d);
      ce_q        <= (state_d == StCapture);
      se_q        <= (state_d == StShift);
      ue_q        <= (state_d == StUpdate);
      rsp_valid_q <= (state_d == StDone);
    end
  end

  firebird7_in_gate2_ijtag_drv_shreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_W      (LEN_W)
  ) u_shreg (
    .clk        (ijtag_tck),
    .rst_n      (ijtag_reset),
    .load       (accept),
    .load_data  (bus.req_data),
    .shift_en   (state_d == StShift),
    .sample_en  (state_q == StShift),
    .sample_idx (cnt_q),
    .so         (ijtag_so),
    .si         (ijtag_si),
    .rsp_data   (bus.rsp_data)
  );

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign ijtag_sel     = sel_q;
  assign ijtag_ce      = ce_q;
  assign ijtag_se      = se_q;
  assign ijtag_ue      = ue_q;

endmodule
